// File: rtl/prog_countdown_pkg.sv
// Shared types and constants for the programmable countdown timer.
package prog_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } chan_state_t;

  // Widest channel count supported; narrower channels truncate the reset constant.
  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] RESET_COUNT_ALL = '1;

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: state machine, count and reload registers, expiry flags.
import prog_countdown_pkg::*;

module countdown_channel #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             clear_expired,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             expire_pulse,
  output logic             running
);

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_COUNT_ALL);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO        = '0;

  chan_state_t      state;
  logic [WIDTH-1:0] reload;

  // Priority: load > clear_expired > stop > start > decrement.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      count        <= RESET_COUNT;
      reload       <= RESET_COUNT;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      if (load) begin
        count   <= load_value;
        reload  <= load_value;
        state   <= ST_IDLE;
        expired <= 1'b0;
      end else if (clear_expired) begin
        expired <= 1'b0;
        if (state == ST_EXPIRED) begin
          count <= reload;
          state <= ST_IDLE;
        end
      end else if (stop) begin
        if (state == ST_RUNNING) state <= ST_PAUSED;
      end else begin
        case (state)
          ST_IDLE, ST_PAUSED: begin
            if (start) state <= ST_RUNNING;
          end
          ST_RUNNING: begin
            if (count == ONE) begin
              count        <= ZERO;
              expired      <= 1'b1;
              expire_pulse <= 1'b1;
              if (!auto_reload) state <= ST_EXPIRED;
            end else if (count == ZERO) begin
              // A zero count either reloads silently or expires immediately.
              if (auto_reload) begin
                count <= reload;
              end else begin
                state        <= ST_EXPIRED;
                expired      <= 1'b1;
                expire_pulse <= 1'b1;
              end
            end else begin
              count <= count - ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign running = (state == ST_RUNNING);

endmodule

// File: rtl/prog_countdown_timer.sv
// Multi-channel programmable countdown timer: replicated channels plus bus packing.
import prog_countdown_pkg::*;

module prog_countdown_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       auto_reload,
  input  logic [CHANNELS-1:0]       clear_expired,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS-1:0]       expire_pulse,
  output logic [CHANNELS-1:0]       running,
  output logic                      any_expired
);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
    countdown_channel #(.WIDTH(WIDTH)) u_chan (
      .Clock         (Clock),
      .Reset         (Reset),
      .load          (load[i]),
      .load_value    (load_value),
      .start         (start[i]),
      .stop          (stop[i]),
      .auto_reload   (auto_reload[i]),
      .clear_expired (clear_expired[i]),
      .count         (count_out[i*WIDTH +: WIDTH]),
      .expired       (expired[i]),
      .expire_pulse  (expire_pulse[i]),
      .running       (running[i])
    );
  end

  assign any_expired = |expired;

endmodule

// File: tb/tb_prog_countdown_timer.sv
// Directed self-checking bench for prog_countdown_timer (WIDTH=4, CHANNELS=2).
module tb_prog_countdown_timer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] load, start, stop, auto_reload, clear_expired;
  logic [3:0] load_value;
  logic [7:0] count_out;
  logic [1:0] expired, expire_pulse, running;
  logic       any_expired;

  int checks = 0;
  int errors = 0;

  prog_countdown_timer #(.WIDTH(4), .CHANNELS(2)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .load          (load),
    .load_value    (load_value),
    .start         (start),
    .stop          (stop),
    .auto_reload   (auto_reload),
    .clear_expired (clear_expired),
    .count_out     (count_out),
    .expired       (expired),
    .expire_pulse  (expire_pulse),
    .running       (running),
    .any_expired   (any_expired)
  );

  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic [1:0] exp_e,
                           input logic [1:0] pls, input logic [1:0] run);
    check({tag, ".count"}, 32'(count_out), 32'(cnt));
    check({tag, ".expired"}, 32'(expired), 32'(exp_e));
    check({tag, ".pulse"}, 32'(expire_pulse), 32'(pls));
    check({tag, ".running"}, 32'(running), 32'(run));
    check({tag, ".any"}, 32'(any_expired), 32'(|exp_e));
  endtask

  initial begin
    Reset = 1'b1; load = '0; start = '0; stop = '0; auto_reload = '0;
    clear_expired = '0; load_value = '0;
    tick(); tick();
    Reset = 1'b0;
    check_all("reset", 8'hFF, 2'b00, 2'b00, 2'b00);
    tick();
    check_all("idle_hold", 8'hFF, 2'b00, 2'b00, 2'b00);

    // ch0 load 3, start, count down to expiry
    load = 2'b01; load_value = 4'd3; tick(); load = '0;
    check_all("load3", 8'hF3, 2'b00, 2'b00, 2'b00);
    start = 2'b01; tick(); start = '0;
    check_all("run3", 8'hF3, 2'b00, 2'b00, 2'b01);
    tick(); check_all("dec2", 8'hF2, 2'b00, 2'b00, 2'b01);
    tick(); check_all("dec1", 8'hF1, 2'b00, 2'b00, 2'b01);
    tick(); check_all("exp0", 8'hF0, 2'b01, 2'b01, 2'b00);
    tick(); check_all("exp_hold", 8'hF0, 2'b01, 2'b00, 2'b00);

    // EXPIRED ignores start; clear restores reload; load beats start
    start = 2'b01; tick(); start = '0;
    check_all("exp_start_ign", 8'hF0, 2'b01, 2'b00, 2'b00);
    clear_expired = 2'b01; tick(); clear_expired = '0;
    check_all("clear", 8'hF3, 2'b00, 2'b00, 2'b00);
    load = 2'b01; load_value = 4'd5; start = 2'b01; tick(); load = '0; start = '0;
    check_all("load_wins", 8'hF5, 2'b00, 2'b00, 2'b00);

    // pause and resume
    start = 2'b01; tick(); start = '0;
    check_all("run5", 8'hF5, 2'b00, 2'b00, 2'b01);
    tick(); check_all("dec4", 8'hF4, 2'b00, 2'b00, 2'b01);
    tick(); check_all("dec3", 8'hF3, 2'b00, 2'b00, 2'b01);
    stop = 2'b01; tick(); stop = '0;
    check_all("pause", 8'hF3, 2'b00, 2'b00, 2'b00);
    tick(); check_all("pause_hold", 8'hF3, 2'b00, 2'b00, 2'b00);
    start = 2'b01; tick(); start = '0;
    check_all("resume", 8'hF3, 2'b00, 2'b00, 2'b01);
    tick(); check_all("r_dec2", 8'hF2, 2'b00, 2'b00, 2'b01);
    tick(); check_all("r_dec1", 8'hF1, 2'b00, 2'b00, 2'b01);
    tick(); check_all("r_exp", 8'hF0, 2'b01, 2'b01, 2'b00);
    clear_expired = 2'b01; tick(); clear_expired = '0;
    check_all("clear5", 8'hF5, 2'b00, 2'b00, 2'b00);

    // ch1 periodic mode, reload 2 -> period 3
    auto_reload = 2'b10;
    load = 2'b10; load_value = 4'd2; tick(); load = '0;
    check_all("ar_load", 8'h25, 2'b00, 2'b00, 2'b00);
    start = 2'b10; tick(); start = '0;
    check_all("ar_run", 8'h25, 2'b00, 2'b00, 2'b10);
    tick(); check_all("ar_1", 8'h15, 2'b00, 2'b00, 2'b10);
    tick(); check_all("ar_0", 8'h05, 2'b10, 2'b10, 2'b10);
    tick(); check_all("ar_rel", 8'h25, 2'b10, 2'b00, 2'b10);
    tick(); check_all("ar_1b", 8'h15, 2'b10, 2'b00, 2'b10);
    tick(); check_all("ar_0b", 8'h05, 2'b10, 2'b10, 2'b10);
    tick(); check_all("ar_relb", 8'h25, 2'b10, 2'b00, 2'b10);
    clear_expired = 2'b10; tick(); clear_expired = '0;
    check("ar_clear.expired", 32'(expired), 32'd0);
    check("ar_clear.running", 32'(running), 32'b10);
    check("ar_clear.ch0", 32'(count_out[3:0]), 32'h5);
    stop = 2'b10; auto_reload = '0; tick(); stop = '0;
    check("ar_stop.running", 32'(running), 32'd0);

    // reset mid-run abandons the count with no pulse
    load = 2'b01; load_value = 4'd9; tick(); load = '0;
    start = 2'b01; tick(); start = '0;
    tick(); tick();
    check("mid_run.ch0", 32'(count_out[3:0]), 32'h7);
    check("mid_run.running", 32'(running[0]), 32'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check_all("mid_reset", 8'hFF, 2'b00, 2'b00, 2'b00);

    // load 0 then start -> immediate expiry with one pulse
    load = 2'b01; load_value = 4'd0; tick(); load = '0;
    check_all("zero_load", 8'hF0, 2'b00, 2'b00, 2'b00);
    start = 2'b01; tick(); start = '0;
    check_all("zero_run", 8'hF0, 2'b00, 2'b00, 2'b01);
    tick(); check_all("zero_exp", 8'hF0, 2'b01, 2'b01, 2'b00);
    tick(); check_all("zero_hold", 8'hF0, 2'b01, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
